// File: rtl/pe_feeder_pkg.sv
// Shared encodings for the PE operand feeder: FSM states, beat kinds and lane modes.
package pe_feeder_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WLOAD  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  localparam logic KIND_W = 1'b0;
  localparam logic KIND_X = 1'b1;

  localparam logic MODE_16  = 1'b0;
  localparam logic MODE_8X2 = 1'b1;

endpackage

// File: rtl/pe_feeder_sm_conv16_8.sv
// Two's-complement to sign-magnitude converter: one 16-bit operand or two independent 8-bit lanes.
module sm_conv16_8
  import pe_feeder_pkg::*;
(
  input  logic              mode,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] magnitude,
  output logic [1:0]        sign
);

  // The most negative value wraps onto itself, which is exactly its unsigned magnitude.
  function automatic logic [15:0] abs16(input logic [15:0] v);
    logic [15:0] r;
    r = v[15] ? (~v + 16'd1) : v;
    return r;
  endfunction

  function automatic logic [7:0] abs8(input logic [7:0] v);
    logic [7:0] r;
    r = v[7] ? (~v + 8'd1) : v;
    return r;
  endfunction

  always_comb begin
    magnitude = '0;
    sign      = 2'b00;
    if (mode == MODE_8X2) begin
      magnitude = {abs8(data[15:8]), abs8(data[7:0])};
      sign      = {data[15], data[7]};
    end else begin
      magnitude = abs16(data);
      sign      = {data[15], data[15]};
    end
  end

endmodule

// File: rtl/pe_feeder.sv
// Job sequencer feeding one weight then cfg_len converted activations to a processing element.
module pe_feeder
  import pe_feeder_pkg::*;
#(
  parameter int DRAIN_CYC = 2,
  parameter int LEN_W     = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic              cfg_mode,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_kind,
  input  logic [DATA_W-1:0] s_data,
  output logic              mode,
  output logic [DATA_W-1:0] Win,
  output logic              Wrecv,
  output logic [DATA_W-1:0] Xin,
  output logic [1:0]        Xsign,
  output logic              enable,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DCNT_W = $clog2(DRAIN_CYC + 2);

  state_t              state;
  logic [LEN_W-1:0]    cnt;
  logic [DCNT_W-1:0]   dcnt;
  logic                vld_p0;
  logic [DATA_W-1:0]   conv_mag;
  logic [1:0]          conv_sign;

  assign vld_p0 = s_valid & s_ready;

  sm_conv16_8 u_conv (
    .mode      (mode),
    .data      (s_data),
    .magnitude (conv_mag),
    .sign      (conv_sign)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      dcnt    <= '0;
      mode    <= MODE_16;
      Win     <= '0;
      Wrecv   <= 1'b0;
      Xin     <= '0;
      Xsign   <= 2'b00;
      enable  <= 1'b0;
      s_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      // ---- stage p0 -> p1: accepted beat becomes a one-cycle strobe to the PE ----
      Wrecv  <= 1'b0;
      enable <= 1'b0;
      Xin    <= '0;
      Xsign  <= 2'b00;
      done   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            mode    <= cfg_mode;
            cnt     <= cfg_len;
            err     <= 1'b0;
            state   <= ST_WLOAD;
            s_ready <= 1'b1;
            busy    <= 1'b1;
          end
        end

        ST_WLOAD: begin
          if (vld_p0) begin
            if (s_kind == KIND_W) begin
              Win   <= s_data;
              Wrecv <= 1'b1;
              if (cnt == '0) begin
                state   <= ST_DRAIN;
                s_ready <= 1'b0;
                dcnt    <= '0;
              end else begin
                state <= ST_STREAM;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end

        ST_STREAM: begin
          if (vld_p0) begin
            if (s_kind == KIND_X) begin
              enable <= 1'b1;
              Xin    <= conv_mag;
              Xsign  <= conv_sign;
              cnt    <= cnt - LEN_W'(1);
              if (cnt == LEN_W'(1)) begin
                state   <= ST_DRAIN;
                s_ready <= 1'b0;
                dcnt    <= '0;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          // The cycle carrying the final strobe counts as drain cycle zero.
          if (dcnt == DCNT_W'(DRAIN_CYC)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            dcnt <= dcnt + DCNT_W'(1);
          end
        end

        default: begin
          state   <= ST_IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 SHALL have parameter DRAIN_CYC, default 2, giving the idle cycles after the last activation before done.
REQ-002 SHALL have parameter LEN_W, default 16, giving the width of the activation-count field.
REQ-003 SHALL have ports:
- clk  in  1  single clock for all state; outputs update on rising edge.
- res  in  1  asynchronous active-high reset.
- start  in  1  job start pulse.
- cfg_mode  in  1  1 = dual 8-bit lanes, 0 = 16-bit.
- cfg_len  in  LEN_W  activation beats per job.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  upstream beat accepted when s_valid and s_ready are both high.
- s_kind  in  1  0 = weight beat, 1 = activation beat.
- s_data  in  16  two's-complement operand; in 8-bit mode two lanes [15:8] and [7:0].
- mode  out  1  mode to the PE.
- Win  out  16  raw weight.
- Wrecv  out  1  weight-load strobe.
- Xin  out  16  activation magnitude.
- Xsign  out  2  activation sign per lane.
- enable  out  1  accumulate-valid to the PE.
- busy  out  1  job in progress.
- done  out  1  one-cycle end-of-job pulse.
- err  out  1  sticky protocol error.

Function
REQ-004 SHALL implement FSM IDLE -> WLOAD -> STREAM -> DRAIN -> IDLE.
REQ-005 IDLE: s_ready=0; start=1 latches cfg_mode into mode, loads a beat counter with cfg_len, clears err, and moves to WLOAD.
REQ-006 WLOAD: s_ready=1; on accepted beat with s_kind=0, next cycle Win=s_data and Wrecv=1 for exactly one cycle, then STREAM (or DRAIN if cfg_len=0).
REQ-007 WLOAD beat with s_kind=1 SHALL be consumed and dropped, set err, and keep the FSM in WLOAD.
REQ-008 STREAM: s_ready=1; each accepted s_kind=1 beat SHALL produce enable=1 with converted Xin/Xsign on the next cycle (latency 1) and decrement the counter.
REQ-009 STREAM cycles with no accepted beat SHALL drive enable=0 and Xin=0, Xsign=0; gaps are allowed.
REQ-010 STREAM s_kind=0 beats SHALL be dropped and set err; they do not decrement the counter.
REQ-011 Acceptance of the counter-reaching-zero beat SHALL move the FSM to DRAIN in the same edge; s_ready SHALL be 0 from the next cycle.
REQ-012 DRAIN: enable=0, Xin=0, for DRAIN_CYC cycles, then done=1 for one cycle and return to IDLE.
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 start while busy=1 SHALL be ignored and SHALL NOT set err.
REQ-015 16-bit conversion: Xin = |s_data| as 16-bit unsigned (-32768 -> 0x8000); Xsign = {neg, neg}.
REQ-016 8-bit conversion: each lane is converted independently, with Xin[15:8]/Xsign[1] from [15:8] and Xin[7:0]/Xsign[0] from [7:0]; -128 -> 0x80.
REQ-017 Zero operand SHALL give sign 0; Win SHALL pass s_data unconverted.
REQ-018 mode SHALL change only on a start accepted in IDLE, so it is constant for a whole job.
REQ-019 Win SHALL hold its last value when Wrecv=0.

Reset
REQ-020 res=1 SHALL asynchronously force IDLE, counter 0, mode=0, Win=0, Wrecv=0, Xin=0, Xsign=0, enable=0, s_ready=0, busy=0, done=0, err=0.
REQ-021 Reset mid-job SHALL abort with no done pulse; the first start after release begins a fresh job.

Structure
REQ-022 A shared package SHALL hold the FSM state encoding, the s_kind codes (KIND_W=0, KIND_X=1) and the mode codes (MODE_16=0, MODE_8X2=1).
REQ-023 The sign-magnitude conversion SHALL be one combinational sub-module, sm_conv16_8 (inputs: mode, data; outputs: magnitude, sign[1:0]).

Verification
REQ-024 Bench SHALL run: mode 0, cfg_len=3, weight 0x0005, activations 0x0003, 0xFFFD, 0x8000 -> one Wrecv with Win=0x0005; Xin/Xsign = 0x0003/00, 0x0003/11, 0x8000/11 on three enable cycles; done exactly 3 cycles after the last enable (DRAIN_CYC=2).
REQ-025 Bench SHALL run: mode 1, activation 0x80FF -> Xin=0x8001, Xsign=2'b11; activation 0x7F00 -> Xin=0x7F00, Xsign=2'b00.
REQ-026 Bench SHALL run: cfg_len=0 -> Wrecv pulse, no enable, done after DRAIN_CYC+1 cycles.
REQ-027 Bench SHALL run: activation beat sent in WLOAD -> beat dropped, err=1, FSM waits for the weight; a second start mid-job -> ignored.
REQ-028 Bench SHALL run: s_valid toggled every other cycle in STREAM -> enable follows the accepted beats with 1-cycle latency, and the enable count equals cfg_len.
REQ-029 Bench SHALL run: res asserted mid-STREAM -> all outputs at reset values immediately, no done pulse, and the next job completes normally.
